hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Cycle-level sequencer for multi-cycle and pipeline-disturbing instructions.
- Sits beside the decode-stage control unit.
- Drives its NopSignal, LDM two-word handshake, flush/bubble insertion for taken jumps and RET/RTI, and the INT entry sequence (push PC, push flags, vector).
- Replaces the combinational St/Sst and FlushNum feedback with one registered FSM.

Parameters:
OPW, 5, opcode width
RET_BUBBLES, 2, bubbles inserted for RET/RTI (legal 1..7)
JMP_BUBBLES, 1, bubbles after a taken branch/jump/call (legal 1..7)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  decode-stage instruction valid
id_opcode  in  OPW  decode-stage opcode (`OP_* encodings from defines.v)
branch_taken  in  1  EX-stage jump/call resolved taken
int_pin  in  1  external interrupt request, level
stall_in  in  1  load-use stall from hazard detection; freezes sequencer
nop_signal  out  1  control unit must emit all-zero signals / ALU_NOP
imm_phase  out  1  current IF/ID word is the LDM immediate
pc_hold  out  1  PC and IF/ID hold
flush_if_id  out  1  clear IF/ID register
pc_src  out  2  00 sequential, 01 branch target, 10 stack (RET/RTI), 11 interrupt vector
int_push  out  2  01 push PC, 10 push flags, 00 none
int_ack  out  1  one-cycle pulse on interrupt acceptance
busy  out  1  state != IDLE

Behaviour:
- Reset: one clk with rst=1 gives state IDLE, counter 0, int_pending 0. All outputs 0. Reset mid-sequence aborts immediately; no partial push completes.
- States: IDLE, IMM, FLUSH, INT_PC, INT_FLG, INT_VEC. 3-bit down-counter cnt.
- Outputs are Moore, decoded from the registered state. Only exception: the IDLE branch response is same-cycle.
- int_pending: set on int_pin rising edge (sampled register). Sticky. Cleared only by int_ack. A rising edge in the same cycle as int_ack re-sets it.
- stall_in=1, any state: state, cnt and int_pending (except set) frozen. Outputs pc_hold=1, all others 0.
- IDLE priority, highest first, evaluated when stall_in=0:
  1. branch_taken: flush_if_id=1, pc_src=01 this cycle. If JMP_BUBBLES>1, go FLUSH with cnt=JMP_BUBBLES-1 and pc_src=00 there. Any LDM/RET/INT decode this cycle is dropped as wrong-path.
  2. id_valid and `OP_LDM: next IMM.
  3. id_valid and `OP_Ret/`OP_RTI: next FLUSH, cnt=RET_BUBBLES, RET flag set.
  4. int_pending: int_ack=1, go INT_PC.
  5. else stay IDLE, all outputs 0.
- IMM: one cycle, imm_phase=1, nop_signal=0. Next IDLE. Interrupts deferred; the LDM pair is atomic. branch_taken in IMM is ignored.
- FLUSH: nop_signal=1, flush_if_id=1, pc_hold=1. cnt decrements each cycle. On cnt==1, if RET flag: pc_src=10, pc_hold=0. Next IDLE, RET flag cleared.
- INT_PC: int_push=01, nop_signal=1, pc_hold=1.
- INT_FLG: int_push=10, nop_signal=1, pc_hold=1.
- INT_VEC: pc_src=11, flush_if_id=1. Next IDLE.
- branch_taken, LDM and RET decodes are ignored outside IDLE, since the pipeline holds during the sequence.
- Interrupt latency: acceptance is no earlier than the first non-stalled IDLE cycle after the edge. A new interrupt during INT_* is serviced at the earliest in the IDLE cycle following INT_VEC.
- Counter never wraps. Out-of-range bubble parameters are a build-time error (generate check).

Decomposition:
- Shared package/defines.v additions: state encodings ST_IDLE..ST_INT_VEC; PCSRC_SEQ/BR/STK/VEC; PUSH_NONE/PC/FLG.
- `OP_* opcodes are reused unchanged.
- One sub-module: edge_latch (rising-edge detect + sticky pending with clear), for int_pin.

Test Plan:
- rst high 2 cycles mid-INT_FLG -> next cycle all outputs 0, busy=0, int_push=00. A later single int_pin edge yields exactly one int_ack.
- id_valid=1, opcode=`OP_LDM at cycle N -> imm_phase=1 at N+1 only. int_pin edge at N -> int_ack at N+2, not N+1.
- `OP_Ret at N with RET_BUBBLES=2 -> nop_signal/flush_if_id=1 at N+1, N+2. pc_src=10 at N+2 only. IDLE at N+3.
- branch_taken=1 with `OP_LDM in ID at N -> flush_if_id=1, pc_src=01 at N. imm_phase never asserts.
- int_pin rises at N, idle -> int_ack at N+1. int_push=01 at N+2, 10 at N+3. pc_src=11 with flush_if_id=1 at N+4.
- stall_in=1 for 3 cycles inside FLUSH (cnt=2) -> pc_hold=1, nop_signal=0, cnt unchanged. Remaining 2 bubbles resume after release.

Source files
------------

// File: rtl/hazard_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_sequencer_pkg
//  Purpose  : Shared encodings for the decode-stage hazard sequencer: FSM state
//             codes, PC source selects, interrupt push selects and the opcodes
//             the sequencer reacts to.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_sequencer_pkg;

    localparam int OPW_DEF = 5;

    // Sequencer state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_IMM     = 3'd1;
    localparam logic [2:0] ST_FLUSH   = 3'd2;
    localparam logic [2:0] ST_INT_PC  = 3'd3;
    localparam logic [2:0] ST_INT_FLG = 3'd4;
    localparam logic [2:0] ST_INT_VEC = 3'd5;

    // PC source selects
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_STK = 2'b10;
    localparam logic [1:0] PCSRC_VEC = 2'b11;

    // Interrupt-entry stack push selects
    localparam logic [1:0] PUSH_NONE = 2'b00;
    localparam logic [1:0] PUSH_PC   = 2'b01;
    localparam logic [1:0] PUSH_FLG  = 2'b10;

    // Opcodes shared with the control unit (same values as the OP_* defines)
    localparam logic [OPW_DEF-1:0] OP_NOP = 5'd0;
    localparam logic [OPW_DEF-1:0] OP_LDM = 5'd20;
    localparam logic [OPW_DEF-1:0] OP_RET = 5'd26;
    localparam logic [OPW_DEF-1:0] OP_RTI = 5'd27;

endpackage
`default_nettype wire

// File: rtl/hazard_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_sequencer_if
//  Purpose  : Bundles the decode/EX-side requests into the sequencer and the
//             pipeline-control responses coming back out of it.
//  Ports    : master - decode side (drives requests, receives controls)
//             slave  - sequencer  (receives requests, drives controls)
//  Revision : 1.0 - initial release
// ============================================================================
interface hazard_sequencer_if #(
    parameter int OPW = 5
);
    logic           id_valid;
    logic [OPW-1:0] id_opcode;
    logic           branch_taken;
    logic           int_pin;
    logic           stall_in;

    logic           nop_signal;
    logic           imm_phase;
    logic           pc_hold;
    logic           flush_if_id;
    logic [1:0]     pc_src;
    logic [1:0]     int_push;
    logic           int_ack;
    logic           busy;

    modport master (
        output id_valid, id_opcode, branch_taken, int_pin, stall_in,
        input  nop_signal, imm_phase, pc_hold, flush_if_id, pc_src,
               int_push, int_ack, busy
    );

    modport slave (
        input  id_valid, id_opcode, branch_taken, int_pin, stall_in,
        output nop_signal, imm_phase, pc_hold, flush_if_id, pc_src,
               int_push, int_ack, busy
    );
endinterface
`default_nettype wire

// File: rtl/hazard_sequencer_edge_latch.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_sequencer_edge_latch
//  Purpose  : Rising-edge detector with a sticky pending flag. A rising edge
//             sets the flag, i_clr clears it; an edge coinciding with a clear
//             wins so no request is lost.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             i_level       - raw level input
//             i_clr         - clear request (acceptance pulse)
//             o_pending     - sticky pending flag
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_sequencer_edge_latch (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_level,
    input  wire logic i_clr,
    output logic      o_pending
);
    logic r_prev;
    logic r_pending;
    logic w_rise;

    assign w_rise    = i_level & ~r_prev;
    assign o_pending = r_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_prev    <= i_level;
            r_pending <= w_rise | (r_pending & ~i_clr);
        end
    end
endmodule
`default_nettype wire

// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_sequencer
//  Purpose  : Registered FSM sequencing LDM two-word fetch, taken-branch and
//             RET/RTI bubbles, and the interrupt entry (push PC, push flags,
//             jump to vector). Outputs decode from the registered state; only
//             the IDLE branch flush and interrupt acceptance look at inputs.
//  Ports    : clk, rst - clock, synchronous active-high reset
//             bus      - hazard_sequencer_if.slave (requests in, controls out)
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int OPW         = 5,
    parameter int RET_BUBBLES = 2,
    parameter int JMP_BUBBLES = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_sequencer_if.slave  bus
);
    if (RET_BUBBLES < 1 || RET_BUBBLES > 7) begin : g_bad_ret_bubbles
        $error("RET_BUBBLES must be in 1..7");
    end
    if (JMP_BUBBLES < 1 || JMP_BUBBLES > 7) begin : g_bad_jmp_bubbles
        $error("JMP_BUBBLES must be in 1..7");
    end

    logic [2:0] r_state;
    logic [2:0] r_cnt;
    logic       r_ret;

    logic       w_int_pending;
    logic       w_is_ldm;
    logic       w_is_ret;

    logic       w_nop_signal;
    logic       w_imm_phase;
    logic       w_pc_hold;
    logic       w_flush_if_id;
    logic [1:0] w_pc_src;
    logic [1:0] w_int_push;
    logic       w_int_ack;
    logic       w_busy;

    assign w_is_ldm = bus.id_valid && (bus.id_opcode == OPW'(OP_LDM));
    assign w_is_ret = bus.id_valid && ((bus.id_opcode == OPW'(OP_RET)) ||
                                       (bus.id_opcode == OPW'(OP_RTI)));

    hazard_sequencer_edge_latch u_int_latch (
        .clk       (clk),
        .rst       (rst),
        .i_level   (bus.int_pin),
        .i_clr     (w_int_ack),
        .o_pending (w_int_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_ret   <= 1'b0;
        end else if (!bus.stall_in) begin
            case (r_state)
                ST_IDLE: begin
                    // A taken branch makes whatever sits in ID wrong-path.
                    if (bus.branch_taken) begin
                        if (JMP_BUBBLES > 1) begin
                            r_state <= ST_FLUSH;
                            r_cnt   <= 3'(JMP_BUBBLES - 1);
                            r_ret   <= 1'b0;
                        end
                    end else if (w_is_ldm) begin
                        r_state <= ST_IMM;
                    end else if (w_is_ret) begin
                        r_state <= ST_FLUSH;
                        r_cnt   <= 3'(RET_BUBBLES);
                        r_ret   <= 1'b1;
                    end else if (w_int_pending) begin
                        r_state <= ST_INT_PC;
                    end
                end
                ST_IMM:     r_state <= ST_IDLE;
                ST_FLUSH: begin
                    if (r_cnt <= 3'd1) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 3'd0;
                        r_ret   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_INT_PC:  r_state <= ST_INT_FLG;
                ST_INT_FLG: r_state <= ST_INT_VEC;
                ST_INT_VEC: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_nop_signal  = 1'b0;
        w_imm_phase   = 1'b0;
        w_pc_hold     = 1'b0;
        w_flush_if_id = 1'b0;
        w_pc_src      = PCSRC_SEQ;
        w_int_push    = PUSH_NONE;
        w_int_ack     = 1'b0;
        w_busy        = 1'b0;
        if (bus.stall_in) begin
            w_pc_hold = 1'b1;
        end else begin
            w_busy = (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (bus.branch_taken) begin
                        w_flush_if_id = 1'b1;
                        w_pc_src      = PCSRC_BR;
                    end else if (!w_is_ldm && !w_is_ret && w_int_pending) begin
                        w_int_ack = 1'b1;
                    end
                end
                ST_IMM: w_imm_phase = 1'b1;
                ST_FLUSH: begin
                    w_nop_signal  = 1'b1;
                    w_flush_if_id = 1'b1;
                    w_pc_hold     = 1'b1;
                    // Last RET bubble releases the PC to the popped address.
                    if (r_cnt == 3'd1 && r_ret) begin
                        w_pc_src  = PCSRC_STK;
                        w_pc_hold = 1'b0;
                    end
                end
                ST_INT_PC: begin
                    w_int_push   = PUSH_PC;
                    w_nop_signal = 1'b1;
                    w_pc_hold    = 1'b1;
                end
                ST_INT_FLG: begin
                    w_int_push   = PUSH_FLG;
                    w_nop_signal = 1'b1;
                    w_pc_hold    = 1'b1;
                end
                ST_INT_VEC: begin
                    w_pc_src      = PCSRC_VEC;
                    w_flush_if_id = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.nop_signal  = w_nop_signal;
    assign bus.imm_phase   = w_imm_phase;
    assign bus.pc_hold     = w_pc_hold;
    assign bus.flush_if_id = w_flush_if_id;
    assign bus.pc_src      = w_pc_src;
    assign bus.int_push    = w_int_push;
    assign bus.int_ack     = w_int_ack;
    assign bus.busy        = w_busy;
endmodule
`default_nettype wire
